alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Upstream feed stage for the 4-bit ALU top. Buffers 13-bit instruction words {A[3:0],B[3:0],OPCODE[4:0]}
//  in a FIFO and drives the head word onto the ALU's combinational 13-bit input.
//  Registers the ALU's result and carry, tagged with the opcode, behind a valid/ready output.
//  Turns the purely combinational ALU into a flow-controlled, single-issue pipeline stage.
// PARAMETERS
//  DEPTH    4    FIFO entries; power of two, >=2
//  CNT_W    3    width of fill_level; must be $clog2(DEPTH+1)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  flush        in   1      synchronous clear of FIFO and output register
//  in_valid     in   1      upstream word valid
//  in_ready     out  1      FIFO can accept (count<DEPTH)
//  in_word      in   13     {A,B,OPCODE}, same packing as ALU top input
//  alu_in       out  13     head word to ALU input; 13'b0 when FIFO empty
//  alu_result   in   4      ALU result (combinational from alu_in)
//  alu_carry    in   1      ALU carry (adder carry, all opcodes)
//  out_valid    out  1      registered result valid
//  out_ready    in   1      downstream accepts result
//  out_result   out  4      captured result
//  out_carry    out  1      captured carry
//  out_opcode   out  5      opcode of captured word
//  fill_level   out  CNT_W  FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty, fill_level=0, in_ready=1, out_valid=0, out_result=0, out_carry=0, out_opcode=0, alu_in=0.
//  Push: in_valid&in_ready at edge -> word written at wr_ptr, wr_ptr wraps modulo DEPTH.
//  Issue: pop=(count!=0)&(~out_valid|out_ready). On pop edge: capture alu_result/carry/opcode, out_valid<=1.
//  Drain: out_valid&out_ready&~pop -> out_valid<=0. Output holds stable while out_valid&~out_ready.
//  Latency: word pushed at edge t is issued no earlier than edge t+1; no FIFO-empty bypass.
//  Throughput: 1 word/cycle when out_ready held high.
//  Simultaneous push+pop: count unchanged; full FIFO still accepts nothing (in_ready from registered count).
//  Empty FIFO: alu_in=0, no pop. Full: in_ready=0, in_valid ignored.
//  Flush: overrides push/pop in that cycle; count=0, pointers=0, out_valid=0; data regs keep value.
//  Reset mid-operation: all state to reset values immediately; in-flight words lost.
//  Word order strictly preserved; no reordering, no drop (except optional trap).
// CONFIGURATION
//  ALU_ISSUE_ILLEGAL_TRAP_EN defined: opcodes 10010-10111 and 11001-11111 are illegal.
//    An illegal head word is popped without producing an output beat (out_valid unaffected).
//    It sets sticky output err_illegal (1 bit, extra port), cleared only by reset or flush.
//  Not defined: no err_illegal port; every word forwarded; ALU decode aliasing applies (e.g. 11111 => SLT).
// TESTING
//  AND: push 1110_1100_00000, out_ready=1 -> next-edge out_valid, out_result=1100, out_carry=1, out_opcode=00000.
//  ADD/SUB back-to-back: push 1110_1100_10000, then 1110_1100_10001 -> 1010/c1, then 0010/c1 on consecutive cycles.
//  Shift/SLT: 1111_1100_01001 -> 0111; 1111_1100_11000 -> 0000; 0001_1100_11000 -> 1111.
//  Backpressure: out_ready=0, push DEPTH+1 words.
//    -> in_ready drops after DEPTH (+1 held in output), fill_level=DEPTH.
//    -> output frozen; release drains in order.
//  Flush/reset: full FIFO with out_valid=1, pulse flush -> next cycle fill_level=0, out_valid=0, in_ready=1.
//    Assert rst_n=0 mid-stream -> outputs zero asynchronously.
//  Trap (macro on): push 1110_1100_10011 then 1110_1100_00001 -> only OR result 1110 emitted, err_illegal=1.
//    Macro off: the same push gives two beats.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Feed stage in front of the 4-bit combinational ALU. Instruction words
//   {A[3:0],B[3:0],OPCODE[4:0]} are queued in a small FIFO. The head word
//   drives the ALU input. The ALU's result and carry are captured, tagged
//   with the opcode, into an output register behind a valid/ready handshake.
//
//   Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN
//     When defined, illegal opcodes (10010-10111, 11001-11111) are popped
//     without producing an output beat and set the sticky err_illegal port.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous clear of FIFO and output valid
//   in_valid/in_ready       upstream handshake, in_word = {A,B,OPCODE}
//   alu_in                  head word to ALU (zero when FIFO empty)
//   alu_result/alu_carry    combinational ALU response to alu_in
//   out_valid/out_ready     downstream handshake
//   out_result/out_carry    captured ALU result and carry
//   out_opcode              opcode of the captured word
//   fill_level              FIFO occupancy
//   err_illegal             sticky illegal-opcode flag (trap build only)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_word,
  output logic [12:0]      alu_in,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic             out_carry,
  output logic [4:0]       out_opcode,
  output logic [CNT_W-1:0] fill_level
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic             err_illegal
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [12:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             emit;

  assign fifo_empty = (count == '0);
  // in_ready comes from the registered count only, so a full FIFO refuses
  // a word even in a cycle where it also pops.
  assign in_ready   = (count < CNT_W'(DEPTH));
  assign push       = in_valid & in_ready;
  assign pop        = ~fifo_empty & (~out_valid | out_ready);
  assign alu_in     = fifo_empty ? 13'b0 : mem[rd_ptr];
  assign fill_level = count;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic [4:0] head_op;
  logic       head_illegal;

  assign head_op      = alu_in[4:0];
  assign head_illegal = ((head_op >= 5'b10010) && (head_op <= 5'b10111)) ||
                        (head_op >= 5'b11001);
  // Illegal heads are consumed but never become an output beat.
  assign emit         = pop & ~head_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else if (flush) begin
      err_illegal <= 1'b0;
    end else if (pop && head_illegal) begin
      err_illegal <= 1'b1;
    end
  end
`else
  assign emit = pop;
`endif

  // Storage needs no reset: alu_in is gated to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data fields survive a flush; only the valid flag is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_opcode <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_carry  <= alu_carry;
      out_opcode <= alu_in[4:0];
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [12:0]      in_word = '0;
  logic [12:0]      alu_in;
  logic [3:0]       alu_result;
  logic             alu_carry;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_result;
  logic             out_carry;
  logic [4:0]       out_opcode;
  logic [CNT_W-1:0] fill_level;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic             err_illegal;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Reference ALU: carry is the adder carry of A+B for every opcode.
  function automatic logic [4:0] alu_f(input logic [12:0] w);
    logic [3:0] a, b, r;
    logic [4:0] op, sum;
    a = w[12:9]; b = w[8:5]; op = w[4:0];
    sum = {1'b0, a} + {1'b0, b};
    if (op[4:3] == 2'b11) r = (a < b) ? 4'hF : 4'h0;
    else begin
      case (op)
        5'b00001: r = a | b;
        5'b00010: r = a ^ b;
        5'b01001: r = a >> 1;
        5'b10000: r = a + b;
        5'b10001: r = a - b;
        default:  r = a & b;
      endcase
    end
    return {sum[4], r};
  endfunction

  function automatic bit illegal_f(input logic [4:0] op);
    return ((op >= 5'b10010) && (op <= 5'b10111)) || (op >= 5'b11001);
  endfunction

  assign {alu_carry, alu_result} = alu_f(alu_in);

  alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .alu_in(alu_in), .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_opcode(out_opcode),
    .fill_level(fill_level)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    , .err_illegal(err_illegal)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural model: a queue of waiting words plus the visible output beat.
  logic [12:0] q[$];
  bit          m_valid = 0;
  logic [3:0]  m_res = '0;
  logic        m_carry = 1'b0;
  logic [4:0]  m_op = '0;
  bit          m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_valid = 0; m_res = '0; m_carry = 1'b0; m_op = '0; m_err = 0;
    end else if (flush) begin
      q.delete(); m_valid = 0; m_err = 0;
    end else begin
      bit do_push, do_pop, trapped;
      logic [12:0] w;
      logic [4:0]  rc;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && (!m_valid || out_ready);
      trapped = 0;
      if (do_pop) begin
        w = q.pop_front();
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        trapped = illegal_f(w[4:0]);
`endif
      end
      if (do_pop && !trapped) begin
        rc = alu_f(w);
        m_valid = 1; m_carry = rc[4]; m_res = rc[3:0]; m_op = w[4:0];
      end else begin
        if (trapped) m_err = 1;
        if (out_ready) m_valid = 0;
      end
      if (do_push) q.push_back(in_word);
    end
  end

  always @(negedge clk) begin
    check("m_out_valid", int'(out_valid), int'(m_valid));
    check("m_out_result", int'(out_result), int'(m_res));
    check("m_out_carry", int'(out_carry), int'(m_carry));
    check("m_out_opcode", int'(out_opcode), int'(m_op));
    check("m_fill_level", int'(fill_level), q.size());
    check("m_in_ready", int'(in_ready), int'(q.size() < DEPTH));
    check("m_alu_in", int'(alu_in), (q.size() != 0) ? int'(q[0]) : 0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("m_err_illegal", int'(err_illegal), int'(m_err));
`endif
  end

  logic [12:0] bp_w [5];
  initial begin
    bp_w[0] = 13'b0011_0101_00000;
    bp_w[1] = 13'b1010_0101_00001;
    bp_w[2] = 13'b1100_0110_00010;
    bp_w[3] = 13'b0111_0010_10000;
    bp_w[4] = 13'b0100_0110_10001;
  end

  task automatic fill_backpressured();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; in_word = bp_w[i];
    end
    @(negedge clk); in_word = 13'b1111_1111_00010;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fill", int'(fill_level), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_alu_in", int'(alu_in), 0);
    rst_n = 1'b1;

    // AND
    @(negedge clk); in_valid = 1'b1; in_word = 13'b1110_1100_00000; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("and_alu_in", int'(alu_in), 13'b1110_1100_00000);
    @(negedge clk);
    check("and_valid", int'(out_valid), 1);
    check("and_result", int'(out_result), 4'b1100);
    check("and_carry", int'(out_carry), 1);
    check("and_opcode", int'(out_opcode), 5'b00000);
    @(negedge clk);
    check("and_drained", int'(out_valid), 0);

    // ADD then SUB back-to-back
    @(negedge clk); in_valid = 1'b1; in_word = 13'b1110_1100_10000;
    @(negedge clk); in_word = 13'b1110_1100_10001;
    @(negedge clk); in_valid = 1'b0;
    check("add_result", int'(out_result), 4'b1010);
    check("add_carry", int'(out_carry), 1);
    @(negedge clk);
    check("sub_valid", int'(out_valid), 1);
    check("sub_result", int'(out_result), 4'b0010);
    check("sub_carry", int'(out_carry), 1);
    @(negedge clk);

    // Shift and SLT
    @(negedge clk); in_valid = 1'b1; in_word = 13'b1111_1100_01001;
    @(negedge clk); in_word = 13'b1111_1100_11000;
    @(negedge clk); in_word = 13'b0001_1100_11000;
    check("shr_result", int'(out_result), 4'b0111);
    @(negedge clk); in_valid = 1'b0;
    check("slt0_result", int'(out_result), 4'b0000);
    @(negedge clk);
    check("slt1_result", int'(out_result), 4'b1111);
    @(negedge clk);

    // Backpressure: DEPTH+1 words, then one refused word
    fill_backpressured();
    check("bp_fill", int'(fill_level), DEPTH);
    check("bp_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check("bp_fill_hold", int'(fill_level), DEPTH);
    check("bp_frozen_op", int'(out_opcode), int'(bp_w[0][4:0]));
    check("bp_frozen_res", int'(out_result), 4'b0001);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("bp_order_valid", int'(out_valid), 1);
      check("bp_order_op", int'(out_opcode), int'(bp_w[k][4:0]));
    end
    @(negedge clk);
    check("bp_empty", int'(out_valid), 0);
    check("bp_in_ready_back", int'(in_ready), 1);

    // Flush of a full FIFO with a held beat
    fill_backpressured();
    check("fl_pre_valid", int'(out_valid), 1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    check("fl_fill", int'(fill_level), 0);
    check("fl_valid", int'(out_valid), 0);
    check("fl_in_ready", int'(in_ready), 1);

    // Asynchronous reset mid-stream
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_word = 13'b1110_1100_00001;
    @(negedge clk); in_word = 13'b1010_0110_00010;
    @(negedge clk); in_valid = 1'b0;
    check("rs_pre_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", int'(out_valid), 0);
    check("rs_result", int'(out_result), 0);
    check("rs_opcode", int'(out_opcode), 0);
    check("rs_fill", int'(fill_level), 0);
    check("rs_alu_in", int'(alu_in), 0);
    @(negedge clk); rst_n = 1'b1;

    // Illegal-opcode word followed by OR
    @(negedge clk); in_valid = 1'b1; in_word = 13'b1110_1100_10011;
    @(negedge clk); in_word = 13'b1110_1100_00001;
    @(negedge clk); in_valid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("trap_no_beat", int'(out_valid), 0);
    check("trap_err", int'(err_illegal), 1);
`else
    check("trap_off_beat", int'(out_valid), 1);
    check("trap_off_op", int'(out_opcode), 5'b10011);
`endif
    @(negedge clk);
    check("or_valid", int'(out_valid), 1);
    check("or_result", int'(out_result), 4'b1110);
    check("or_opcode", int'(out_opcode), 5'b00001);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("trap_err_cleared", int'(err_illegal), 0);
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end
endmodule
